// File: rtl/bcd_digit_stream_counter.sv
// Multi-digit BCD up/down counter with a snapshot-and-stream port (LSD first, valid/ready).
// Optional macro BCD_SNAP_ON_TC_EN: a counting wrap in IDLE starts a snapshot automatically.
module bcd_digit_stream_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  input  logic                snap,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_digit,
  output logic                out_last
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    shift_q;
  logic [IW-1:0]   idx_q;
  logic            out_valid_q, out_last_q;
  logic [3:0]      out_digit_q;
  logic            carry;
  logic            all9, all0;
  logic            start;

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (count_q[4*i +: 4] != 4'd0) all0 = 1'b0;
    end
  end

  assign tc = up ? all9 : all0;

  // Ripple carry/borrow through the digits; a digit only moves while carry is live.
  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++)
        count_d[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end else if (en) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (up) begin
            if (count_q[4*i +: 4] == 4'd9) count_d[4*i +: 4] = 4'd0;
            else begin
              count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (count_q[4*i +: 4] == 4'd0) count_d[4*i +: 4] = 4'd9;
            else begin
              count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

`ifdef BCD_SNAP_ON_TC_EN
  assign start = (state_q == IDLE) && (snap || (en && !load && tc));
`else
  assign start = (state_q == IDLE) && snap;
`endif

  // shift_q holds the digits not yet presented; out_digit_q is the one on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_digit_q <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q     <= count_q >> 4;
            out_digit_q <= count_q[3:0];
            out_last_q  <= (DIGITS == 1);
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end else begin
              out_digit_q <= shift_q[3:0];
              shift_q     <= shift_q >> 4;
              idx_q       <= idx_q + IW'(1);
              out_last_q  <= ((idx_q + IW'(1)) == IW'(DIGITS - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count     = count_q;
  assign busy      = (state_q == SEND);
  assign out_valid = out_valid_q;
  assign out_digit = out_digit_q;
  assign out_last  = out_last_q;
endmodule
